// File: rtl/dot_score_pkg.sv
// dot_score_pkg: shared types and default constants for the dot_score_argmax block.
// Contents: FSM state enum, default widths/counts, and saturation limits for the
// default accumulator width.
package dot_score_pkg;

    typedef enum logic [1:0] {
        StAccum   = 2'd0,
        StCompare = 2'd1,
        StDone    = 2'd2
    } state_e;

    localparam int unsigned DefNumClasses = 10;
    localparam int unsigned DefChunks     = 79;
    localparam int unsigned DefValW       = 27;
    localparam int unsigned DefAccW       = 34;
    localparam int unsigned DefIdxW       = 4;

    // Saturation limits for the default accumulator width.
    localparam logic signed [DefAccW-1:0] DefAccMax = {1'b0, {(DefAccW-1){1'b1}}};
    localparam logic signed [DefAccW-1:0] DefAccMin = {1'b1, {(DefAccW-1){1'b0}}};

endpackage

// File: rtl/dot_score_acc_add.sv
// dot_score_acc_add: combinational signed add of a sign-extended partial value to
// the running accumulator.
// Build option: DOT_SCORE_SAT_EN -- when defined the sum clamps to the signed
// ACC_W max/min on overflow and sat_o flags it; otherwise the sum wraps.
// Ports:
//   acc_i    current accumulator (signed, ACC_W)
//   value_i  incoming partial dot product (signed, VAL_W)
//   sum_o    acc_i + value_i (signed, ACC_W)
//   sat_o    overflow was clamped this add (only with DOT_SCORE_SAT_EN)
module dot_score_acc_add #(
    parameter int unsigned VAL_W = 27,
    parameter int unsigned ACC_W = 34
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [VAL_W-1:0] value_i,
`ifdef DOT_SCORE_SAT_EN
    output logic                    sat_o,
`endif
    output logic signed [ACC_W-1:0] sum_o
);

`ifdef DOT_SCORE_SAT_EN
    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] ext_val;
    logic signed [ACC_W:0] full_sum;

    // One guard bit: overflow iff the two top bits of the widened sum differ.
    assign ext_val  = {{(ACC_W+1-VAL_W){value_i[VAL_W-1]}}, value_i};
    assign full_sum = {acc_i[ACC_W-1], acc_i} + ext_val;

    always_comb begin
        sat_o = 1'b0;
        sum_o = full_sum[ACC_W-1:0];
        if (full_sum[ACC_W] != full_sum[ACC_W-1]) begin
            sat_o = 1'b1;
            sum_o = full_sum[ACC_W] ? AccMin : AccMax;
        end
    end
`else
    logic signed [ACC_W-1:0] ext_val;

    assign ext_val = {{(ACC_W-VAL_W){value_i[VAL_W-1]}}, value_i};
    assign sum_o   = acc_i + ext_val;
`endif

endmodule

// File: rtl/dot_score_argmax.sv
// dot_score_argmax: accumulates per-class partial dot products (CHUNKS values per
// class, classes in order 0..NUM_CLASSES-1) and presents the argmax class and its
// score with a valid/ready handshake.
// Build option: DOT_SCORE_SAT_EN -- saturating accumulation (see dot_score_acc_add).
// Ports:
//   clk, GlobalReset         clock; synchronous active-high reset
//   value, value_valid       incoming signed partial value and its valid
//   value_ready              block accepts a value this cycle (ACCUM only)
//   class_out, score_out     winning class index and score
//   out_valid, out_ready     result handshake
module dot_score_argmax
    import dot_score_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DefNumClasses,
    parameter int unsigned CHUNKS      = DefChunks,
    parameter int unsigned VAL_W       = DefValW,
    parameter int unsigned ACC_W       = DefAccW,
    parameter int unsigned IDX_W       = DefIdxW
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic signed [VAL_W-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [IDX_W-1:0]        class_out,
    output logic signed [ACC_W-1:0] score_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned CntW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CntW-1:0]  LastChunk = CntW'(CHUNKS - 1);
    localparam logic [IDX_W-1:0] LastClass = IDX_W'(NUM_CLASSES - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]         chunk_cnt_q, chunk_cnt_d;
    logic [IDX_W-1:0]        class_cnt_q, class_cnt_d;
    logic signed [ACC_W-1:0] max_score_q, max_score_d;
    logic [IDX_W-1:0]        max_idx_q, max_idx_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;

`ifdef DOT_SCORE_SAT_EN
    logic add_sat;
    logic sat_q;  // sticky: some add in this image clamped
`endif

    dot_score_acc_add #(
        .VAL_W (VAL_W),
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc_i   (acc_q),
        .value_i (value),
`ifdef DOT_SCORE_SAT_EN
        .sat_o   (add_sat),
`endif
        .sum_o   (acc_sum)
    );

    assign accept = (state_q == StAccum) && value_valid;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        chunk_cnt_d = chunk_cnt_q;
        class_cnt_d = class_cnt_q;
        max_score_d = max_score_q;
        max_idx_d   = max_idx_q;
        unique case (state_q)
            StAccum: begin
                if (value_valid) begin
                    acc_d = acc_sum;
                    if (chunk_cnt_q == LastChunk) begin
                        chunk_cnt_d = '0;
                        state_d     = StCompare;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + 1'b1;
                    end
                end
            end
            StCompare: begin
                // Strict compare: on ties the earlier (lower) class is kept.
                if ((class_cnt_q == '0) || (acc_q > max_score_q)) begin
                    max_score_d = acc_q;
                    max_idx_d   = class_cnt_q;
                end
                acc_d       = '0;
                chunk_cnt_d = '0;
                if (class_cnt_q == LastClass) begin
                    class_cnt_d = '0;
                    state_d     = StDone;
                end else begin
                    class_cnt_d = class_cnt_q + 1'b1;
                    state_d     = StAccum;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            chunk_cnt_q <= '0;
            class_cnt_q <= '0;
            max_score_q <= '0;
            max_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            chunk_cnt_q <= chunk_cnt_d;
            class_cnt_q <= class_cnt_d;
            max_score_q <= max_score_d;
            max_idx_q   <= max_idx_d;
        end
    end

`ifdef DOT_SCORE_SAT_EN
    always_ff @(posedge clk) begin
        if (GlobalReset || (state_q == StDone && out_ready)) begin
            sat_q <= 1'b0;
        end else if (accept && add_sat) begin
            sat_q <= 1'b1;
        end
    end
`endif

    // Gated by reset so value_ready reads 0 during the reset cycle itself.
    assign value_ready = (state_q == StAccum) && !GlobalReset;
    assign out_valid   = (state_q == StDone) && !GlobalReset;
    assign class_out   = max_idx_q;
    assign score_out   = max_score_q;

endmodule
